vga_rect_fill: RTL and testbench
================================

// Module: vga_rect_fill
// PURPOSE
//  Drawing engine upstream of the VGA framebuffer/scan-out stage. Accepts axis-aligned
//  rectangle fill commands over a valid/ready handshake and rasterises each one into one
//  framebuffer write per cycle. we_o/addr_x_o/addr_y_o/color_o connect directly to the
//  scan-out block's we_i/addr_x_i/addr_y_i/color_i.
// PARAMETERS
//  HD          1280  display width in pixels; column coordinates are clipped to HD-1
//  VD          1024  display height in pixels; row coordinates are clipped to VD-1
//  COORD_BITS  11    width of every coordinate port and internal counter
// PORTS
//  clk          in   1           system/pixel clock, all logic on rising edge
//  rst          in   1           synchronous reset, active-high
//  cmd_valid_i  in   1           command present on cmd_* inputs
//  cmd_ready_o  out  1           engine can accept a command this cycle
//  cmd_x0_i     in   COORD_BITS  corner A column
//  cmd_y0_i     in   COORD_BITS  corner A row
//  cmd_x1_i     in   COORD_BITS  corner B column (inclusive)
//  cmd_y1_i     in   COORD_BITS  corner B row (inclusive)
//  cmd_color_i  in   2           pixel code: 0 black, 1 white, 2 blue, 3 green
//  we_o         out  1           framebuffer write strobe, one pixel per asserted cycle
//  addr_x_o     out  COORD_BITS  column of the pixel being written
//  addr_y_o     out  COORD_BITS  row of the pixel being written
//  color_o      out  2           pixel code being written
//  busy_o       out  1           high from command accept until done_o
//  done_o       out  1           one-cycle pulse when a command completes
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready_o=1; we_o, busy_o, done_o = 0; addr_x_o, addr_y_o, color_o = 0.
//    rst mid-command aborts immediately: no further writes, no done_o pulse.
//  - FSM IDLE -> CLIP -> FILL -> DONE -> IDLE. cmd_ready_o = (state==IDLE); a command is
//    accepted on the cycle cmd_valid_i && cmd_ready_o. Inputs are sampled only on accept.
//  - CLIP (1 cycle): xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1). If xs>=HD or
//    ys>=VD: rectangle is off-screen, go to DONE with zero writes. Else xe=min(xe,HD-1),
//    ye=min(ye,VD-1); x=xs, y=ys; go to FILL.
//  - FILL: we_o=1 every cycle with addr=(x,y), color_o=latched color. Row-major raster: if x<xe,
//    x++; else x=xs, y++. When x==xe && y==ye the write is the last one; go to DONE.
//    Writes per command = (xe-xs+1)*(ye-ys+1); no gaps, no backpressure on the write side.
//  - Latency: first we_o 2 cycles after the accept edge (accept cycle N, CLIP N+1, first write N+2).
//  - DONE (1 cycle): done_o=1, busy_o=1, we_o=0; next cycle IDLE with cmd_ready_o=1.
//    Minimum spacing between accepts: pixel count + 3 cycles.
//  - busy_o = (state != IDLE). we_o is 0 in every state except FILL.
//  - Degenerate rectangles (x0==x1 and/or y0==y1) are valid: single column/row/pixel.
//  - All comparisons unsigned at COORD_BITS; counters never exceed the clipped bounds, so no
//    wrap-around is possible at the HD-1/VD-1 edges.
// CONFIGURATION
//  VGA_RECT_OUTLINE_EN defined: extra input cmd_outline_i (1 bit), sampled on accept. When it is
//    1, only the border is drawn: rows ys and ye are written in full; interior rows write x=xs
//    then x=xe only (single write if xs==xe). Clipped edges count as the border.
//    Write count = 2*W + 2*(H-2) for W,H>=2. When cmd_outline_i is 0, the engine does a full fill.
//  VGA_RECT_OUTLINE_EN undefined: port absent; every command is a full fill.
// TESTING
//  1. rst held 3 cycles -> cmd_ready_o=1, we_o=busy_o=done_o=0, all addr outputs 0.
//  2. Fill (2,3)-(4,4), color 2 -> 6 writes in order (2,3)(3,3)(4,3)(2,4)(3,4)(4,4), color_o=2,
//     first write 2 cycles after accept, done_o 1 cycle after last write.
//  3. Swapped corners (4,4)-(2,3) -> same 6 writes as test 2. Single pixel (7,7)-(7,7) -> 1 write.
//  4. Clip: (1278,1022)-(2000,2000) -> 4 writes (1278..1279 x 1022..1023). Off-screen
//     (1300,0)-(1400,5) -> zero writes, done_o 2 cycles after accept.
//  5. Back-to-back: cmd_valid_i held with 2 commands -> second accepted the cycle after done_o;
//     cmd_ready_o=0 throughout busy. rst asserted mid-FILL -> we_o=0 next cycle, no done_o.
//  6. VGA_RECT_OUTLINE_EN, outline=1, (0,0)-(3,3) -> 12 writes; interior rows hit x=0 and x=3 only.

Source files
------------

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle fill engine in front of the VGA framebuffer.
// It accepts one rectangle command at a time, clips the rectangle to the
// display, and then writes one pixel per cycle in row-major order.
// Optional feature macro: VGA_RECT_OUTLINE_EN adds the cmd_outline_i input.
// When that input is 1, the engine draws only the border of the rectangle.
//
// state | meaning
// IDLE  | ready for a command; cmd_ready_o high
// CLIP  | order the corners and clip them to the display; check for off-screen
// FILL  | one framebuffer write per cycle at (addr_x_o, addr_y_o)
// DONE  | one-cycle done_o pulse, then return to IDLE
module vga_rect_fill #(
  parameter int HD         = 1280,
  parameter int VD         = 1024,
  parameter int COORD_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [COORD_BITS-1:0] cmd_x0_i,
  input  logic [COORD_BITS-1:0] cmd_y0_i,
  input  logic [COORD_BITS-1:0] cmd_x1_i,
  input  logic [COORD_BITS-1:0] cmd_y1_i,
  input  logic [1:0]            cmd_color_i,
`ifdef VGA_RECT_OUTLINE_EN
  input  logic                  cmd_outline_i,
`endif
  output logic                  we_o,
  output logic [COORD_BITS-1:0] addr_x_o,
  output logic [COORD_BITS-1:0] addr_y_o,
  output logic [1:0]            color_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [COORD_BITS-1:0] HD_M1 = COORD_BITS'(HD - 1);
  localparam logic [COORD_BITS-1:0] VD_M1 = COORD_BITS'(VD - 1);
  localparam logic [COORD_BITS-1:0] ONE   = COORD_BITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  logic [COORD_BITS-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [1:0]            color_q;
  logic [COORD_BITS-1:0] xs_q, xe_q, ys_q, ye_q;

  logic [COORD_BITS-1:0] xs_c, xe_c, ys_c, ye_c, xmax_c, ymax_c;
  logic                  off_c;
  logic [COORD_BITS-1:0] nx_c, ny_c;
  logic                  last_c;
  logic                  skip_c;

`ifdef VGA_RECT_OUTLINE_EN
  logic outline_q;

  // On an interior row of an outline, jump from the left edge straight to the right edge.
  assign skip_c = outline_q && (addr_y_o != ys_q) && (addr_y_o != ye_q) &&
                  (addr_x_o == xs_q) && (xs_q != xe_q);
`else
  assign skip_c = 1'b0;
`endif

  // Order the latched corners and clip the far corner to the display edges.
  always_comb begin
    xs_c   = (x0_q < x1_q) ? x0_q : x1_q;
    xmax_c = (x0_q < x1_q) ? x1_q : x0_q;
    ys_c   = (y0_q < y1_q) ? y0_q : y1_q;
    ymax_c = (y0_q < y1_q) ? y1_q : y0_q;
    off_c  = (xs_c > HD_M1) || (ys_c > VD_M1);
    xe_c   = (xmax_c > HD_M1) ? HD_M1 : xmax_c;
    ye_c   = (ymax_c > VD_M1) ? VD_M1 : ymax_c;
  end

  // Compute the next raster position and detect the final pixel of the rectangle.
  always_comb begin
    nx_c   = addr_x_o;
    ny_c   = addr_y_o;
    last_c = (addr_x_o == xe_q) && (addr_y_o == ye_q);
    if (skip_c) begin
      nx_c = xe_q;
    end else if (addr_x_o < xe_q) begin
      nx_c = addr_x_o + ONE;
    end else begin
      nx_c = xs_q;
      ny_c = addr_y_o + ONE;
    end
  end

  // Sequencing FSM; every output is registered and follows the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      we_o        <= 1'b0;
      addr_x_o    <= '0;
      addr_y_o    <= '0;
      color_o     <= 2'd0;
      x0_q        <= '0;
      y0_q        <= '0;
      x1_q        <= '0;
      y1_q        <= '0;
      color_q     <= 2'd0;
      xs_q        <= '0;
      xe_q        <= '0;
      ys_q        <= '0;
      ye_q        <= '0;
`ifdef VGA_RECT_OUTLINE_EN
      outline_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            x0_q        <= cmd_x0_i;
            y0_q        <= cmd_y0_i;
            x1_q        <= cmd_x1_i;
            y1_q        <= cmd_y1_i;
            color_q     <= cmd_color_i;
`ifdef VGA_RECT_OUTLINE_EN
            outline_q   <= cmd_outline_i;
`endif
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= CLIP;
          end
        end
        CLIP: begin
          xs_q    <= xs_c;
          xe_q    <= xe_c;
          ys_q    <= ys_c;
          ye_q    <= ye_c;
          color_o <= color_q;
          if (off_c) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            we_o     <= 1'b1;
            addr_x_o <= xs_c;
            addr_y_o <= ys_c;
            state    <= FILL;
          end
        end
        FILL: begin
          if (last_c) begin
            we_o   <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            addr_x_o <= nx_c;
            addr_y_o <= ny_c;
          end
        end
        DONE: begin
          done_o      <= 1'b0;
          busy_o      <= 1'b0;
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Testbench for vga_rect_fill. It compares the DUT against a pixel-set model of the
// clipped rectangle, and of its border when VGA_RECT_OUTLINE_EN is defined.
module tb_vga_rect_fill;

  localparam int HD = 1280;
  localparam int VD = 1024;
  localparam int CB = 11;
`ifdef VGA_RECT_OUTLINE_EN
  localparam bit OUTLINE_BUILD = 1'b1;
`else
  localparam bit OUTLINE_BUILD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CB-1:0] cx0 = '0, cy0 = '0, cx1 = '0, cy1 = '0;
  logic [1:0]    ccol = 2'd0;
  logic          coutline = 1'b0;
  logic          we;
  logic [CB-1:0] ax, ay;
  logic [1:0]    color;
  logic          busy, done;

  int checks = 0;
  int failures = 0;
  logic [2*CB-1:0] exp_q[$];

  vga_rect_fill #(.HD(HD), .VD(VD), .COORD_BITS(CB)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_x0_i(cx0), .cmd_y0_i(cy0), .cmd_x1_i(cx1), .cmd_y1_i(cy1),
    .cmd_color_i(ccol),
`ifdef VGA_RECT_OUTLINE_EN
    .cmd_outline_i(coutline),
`endif
    .we_o(we), .addr_x_o(ax), .addr_y_o(ay), .color_o(color),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Reference model: the set of pixels inside the clipped rectangle, listed in row-major order.
  task automatic build_model(input int a0, input int b0, input int a1, input int b1, input bit ol);
    int xs, xe, ys, ye;
    bit border_only;
    exp_q.delete();
    xs = (a0 < a1) ? a0 : a1;
    xe = (a0 < a1) ? a1 : a0;
    ys = (b0 < b1) ? b0 : b1;
    ye = (b0 < b1) ? b1 : b0;
    if (xs >= HD || ys >= VD) return;
    if (xe > HD - 1) xe = HD - 1;
    if (ye > VD - 1) ye = VD - 1;
    border_only = ol && OUTLINE_BUILD;
    for (int y = ys; y <= ye; y++)
      for (int x = xs; x <= xe; x++)
        if (!border_only || y == ys || y == ye || x == xs || x == xe)
          exp_q.push_back({CB'(x), CB'(y)});
  endtask

  task automatic load_cmd(input int a0, input int b0, input int a1, input int b1,
                          input logic [1:0] c, input bit ol);
    cx0 = CB'(a0); cy0 = CB'(b0); cx1 = CB'(a1); cy1 = CB'(b1);
    ccol = c; coutline = ol;
  endtask

  task automatic run_cmd(input string name, input int a0, input int b0, input int a1,
                         input int b1, input logic [1:0] c, input bit ol);
    logic [2*CB-1:0] got[$];
    int got_k[$];
    int n, done_k, wait_k;
    bit hs_err, col_err;
    build_model(a0, b0, a1, b1, ol);
    n = exp_q.size();
    @(negedge clk);
    wait_k = 0;
    while (!cmd_ready && wait_k < 50) begin @(negedge clk); wait_k++; end
    checks++;
    if (!cmd_ready) begin
      failures++;
      $display("FAIL %s ready_wait: cmd_ready_o=%b required 1", name, cmd_ready);
      return;
    end
    load_cmd(a0, b0, a1, b1, c, ol);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    done_k = -1; hs_err = 0; col_err = 0;
    for (int k = 1; k <= n + 10; k++) begin
      @(negedge clk);
      if (cmd_ready || !busy) hs_err = 1;
      if (we) begin
        got.push_back({ax, ay});
        got_k.push_back(k);
        if (color !== c) col_err = 1;
      end
      if (done) begin done_k = k; break; end
    end
    checks++;
    if (got.size() != n) begin
      failures++;
      $display("FAIL %s write_count: got %0d required %0d", name, got.size(), n);
    end
    for (int i = 0; i < n && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i] || got_k[i] != 2 + i) begin
        failures++;
        $display("FAIL %s write[%0d]: got (%0d,%0d)@%0d required (%0d,%0d)@%0d", name, i,
                 got[i][2*CB-1:CB], got[i][CB-1:0], got_k[i],
                 exp_q[i][2*CB-1:CB], exp_q[i][CB-1:0], 2 + i);
      end
    end
    checks++;
    if (done_k != n + 2) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_k, n + 2);
    end
    checks++;
    if (hs_err || col_err) begin
      failures++;
      $display("FAIL %s busy_ready_color: hs_err=%0d col_err=%0d required 0 0", name, hs_err, col_err);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || we !== 1'b0) begin
      failures++;
      $display("FAIL %s post_idle: ready=%b busy=%b done=%b we=%b required 1 0 0 0",
               name, cmd_ready, busy, done, we);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        ax !== '0 || ay !== '0 || color !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: ready=%b we=%b busy=%b done=%b x=%0d y=%0d c=%0d required 1 0 0 0 0 0 0",
               cmd_ready, we, busy, done, ax, ay, color);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b we=%b busy=%b done=%b required 1 0 0 0",
               cmd_ready, we, busy, done);
    end
  endtask

  task automatic test_fill();
    run_cmd("fill_basic", 2, 3, 4, 4, 2'd2, 1'b0);
    run_cmd("fill_swapped", 4, 4, 2, 3, 2'd1, 1'b0);
    run_cmd("single_pixel", 7, 7, 7, 7, 2'd3, 1'b0);
    run_cmd("single_row", 5, 9, 12, 9, 2'd0, 1'b0);
    run_cmd("single_col", 30, 40, 30, 35, 2'd2, 1'b0);
  endtask

  task automatic test_clip();
    run_cmd("clip_corner", 1278, 1022, 2000, 2000, 2'd1, 1'b0);
    run_cmd("offscreen_x", 1300, 0, 1400, 5, 2'd2, 1'b0);
    run_cmd("offscreen_y", 0, 1024, 3, 1030, 2'd3, 1'b0);
    run_cmd("edge_pixel", 1279, 1023, 1279, 1023, 2'd2, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2*CB-1:0] all_q[$];
    logic [2*CB-1:0] got[$];
    int got_k[$];
    int done_ks[$];
    int p1, p2, rdy_cnt, rdy_k;
    bit comp_err;
    build_model(2, 3, 4, 4, 1'b0);
    all_q = exp_q;
    p1 = exp_q.size();
    build_model(10, 10, 11, 12, 1'b0);
    p2 = exp_q.size();
    foreach (exp_q[i]) all_q.push_back(exp_q[i]);
    @(negedge clk);
    load_cmd(2, 3, 4, 4, 2'd1, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 load_cmd(10, 10, 11, 12, 2'd1, 1'b0);
    rdy_cnt = 0; rdy_k = -100; comp_err = 0;
    for (int k = 1; k <= p1 + p2 + 8; k++) begin
      @(negedge clk);
      if (k == rdy_k + 1) cmd_valid = 1'b0;
      if (cmd_ready === busy) comp_err = 1;
      if (cmd_ready && cmd_valid) begin rdy_cnt++; rdy_k = k; end
      if (we) begin got.push_back({ax, ay}); got_k.push_back(k); end
      if (done) done_ks.push_back(k);
    end
    cmd_valid = 1'b0;
    checks++;
    if (rdy_cnt != 1 || rdy_k != p1 + 3) begin
      failures++;
      $display("FAIL b2b_accept: ready seen %0d times at %0d required once at %0d", rdy_cnt, rdy_k, p1 + 3);
    end
    checks++;
    if (comp_err) begin
      failures++;
      $display("FAIL b2b_ready_busy: cmd_ready_o equalled busy_o in some cycle, required complement");
    end
    checks++;
    if (got.size() != all_q.size()) begin
      failures++;
      $display("FAIL b2b_write_count: got %0d required %0d", got.size(), all_q.size());
    end
    for (int i = 0; i < all_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== all_q[i] || got_k[i] != ((i < p1) ? 2 + i : 5 + i)) begin
        failures++;
        $display("FAIL b2b_write[%0d]: got (%0d,%0d)@%0d required (%0d,%0d)@%0d", i,
                 got[i][2*CB-1:CB], got[i][CB-1:0], got_k[i],
                 all_q[i][2*CB-1:CB], all_q[i][CB-1:0], (i < p1) ? 2 + i : 5 + i);
      end
    end
    checks++;
    if (done_ks.size() != 2 || done_ks[0] != p1 + 2 || done_ks[1] != p1 + p2 + 5) begin
      failures++;
      $display("FAIL b2b_done: got %0d pulses first@%0d required 2 at %0d and %0d",
               done_ks.size(), (done_ks.size() > 0) ? done_ks[0] : -1, p1 + 2, p1 + p2 + 5);
    end
  endtask

  task automatic test_reset_mid();
    bit stray;
    @(negedge clk);
    load_cmd(20, 20, 29, 29, 2'd3, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (we !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_in_fill: we_o=%b required 1", we);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (we !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_abort: we=%b done=%b busy=%b ready=%b required 0 0 0 1", we, done, busy, cmd_ready);
    end
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (we || done || busy) stray = 1;
    end
    checks++;
    if (stray) begin
      failures++;
      $display("FAIL rst_mid_quiet: activity after abort, required none");
    end
  endtask

  function automatic int rnd_corner(input int lim);
    case ($urandom_range(0, 2))
      0: return $urandom_range(0, 40);
      1: return lim - 8 + $urandom_range(0, 12);
      default: return $urandom_range(lim, 2035);
    endcase
  endfunction

  task automatic test_random();
    int a0, b0, a1, b1;
    for (int n = 0; n < 25; n++) begin
      a0 = rnd_corner(HD);
      b0 = rnd_corner(VD);
      a1 = a0 + $urandom_range(0, 12) - 6;
      b1 = b0 + $urandom_range(0, 12) - 6;
      if (a1 < 0) a1 = 0;
      if (b1 < 0) b1 = 0;
      run_cmd("random", a0, b0, a1, b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

`ifdef VGA_RECT_OUTLINE_EN
  task automatic test_outline();
    run_cmd("outline_4x4", 0, 0, 3, 3, 2'd1, 1'b1);
    checks++;
    if (exp_q.size() != 12) begin
      failures++;
      $display("FAIL outline_model_count: got %0d required 12", exp_q.size());
    end
    run_cmd("outline_col", 5, 5, 5, 9, 2'd2, 1'b1);
    run_cmd("outline_clip", 1276, 1020, 1500, 1500, 2'd3, 1'b1);
    run_cmd("outline_off_fill", 0, 0, 3, 3, 2'd0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_clip();
    test_back_to_back();
    test_reset_mid();
`ifdef VGA_RECT_OUTLINE_EN
    test_outline();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
